// File: rtl/response_reorder_buffer_if.sv
// Response/ordered-output/free-handshake bundle for response_reorder_buffer.
// master: environment side (response source, downstream sink, allocator).
// slave:  the reorder buffer itself.
interface response_reorder_buffer_if #(
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_WIDTH-1:0]   rsp_uid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [1:0]            rsp_resp;

    logic                  out_valid;
    logic                  out_ready;
    logic [ID_WIDTH-1:0]   out_id;
    logic [DATA_WIDTH-1:0] out_data;
    logic [1:0]            out_resp;

    logic                  free_req;
    logic [ID_WIDTH-1:0]   unique_id_to_free;
    logic [ID_WIDTH-1:0]   restored_id;

    modport master (
        output rsp_valid, rsp_uid, rsp_data, rsp_resp, out_ready, restored_id,
        input  rsp_ready, out_valid, out_id, out_data, out_resp,
               free_req, unique_id_to_free
    );

    modport slave (
        input  rsp_valid, rsp_uid, rsp_data, rsp_resp, out_ready, restored_id,
        output rsp_ready, out_valid, out_id, out_data, out_resp,
               free_req, unique_id_to_free
    );
endinterface

// File: rtl/response_reorder_buffer.sv
// Reorder buffer for single-beat responses tagged with unique IDs {row, col}.
// Responses land in a NUM_ROWS x NUM_COLS slot matrix and are released per
// row in column order, round-robin across rows, through one output register.
// Each release pulses free_req to the allocator and forwards the original ID
// the allocator returns combinationally on restored_id.
// Optional macro ROB_STATS_EN adds the occupancy and dup_err outputs.
module response_reorder_buffer #(
    parameter int unsigned ID_WIDTH        = 16,
    parameter int unsigned MAX_OUTSTANDING = 16,
    parameter int unsigned NUM_ROWS        = MAX_OUTSTANDING,
    parameter int unsigned NUM_COLS        = MAX_OUTSTANDING,
    parameter int unsigned DATA_WIDTH      = 32
) (
    input  logic clk,
    input  logic rst,
    response_reorder_buffer_if.slave bus
`ifdef ROB_STATS_EN
    ,
    output logic [$clog2(NUM_ROWS*NUM_COLS+1)-1:0] occupancy,
    output logic                                   dup_err
`endif
);
    localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned COL_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int unsigned SLOT_W = ROW_W + COL_W;
    localparam int unsigned PAY_W  = DATA_WIDTH + 2;

    logic [NUM_COLS-1:0] slot_valid [NUM_ROWS];
    logic [COL_W-1:0]    head       [NUM_ROWS];
    logic [ROW_W-1:0]    rr_ptr;
    logic [PAY_W-1:0]    pay_mem    [2**SLOT_W];

    logic [ROW_W-1:0]    wr_row;
    logic [COL_W-1:0]    wr_col;
    logic                wr_en;
    logic [NUM_ROWS-1:0] eligible;
    logic                any_elig;
    logic [ROW_W-1:0]    grant_row;
    logic [COL_W-1:0]    grant_col;
    logic                load;

    assign wr_row = bus.rsp_uid[SLOT_W-1:COL_W];
    assign wr_col = bus.rsp_uid[COL_W-1:0];

    // Upper uid bits above {row, col} carry no information here.
    if (ID_WIDTH > SLOT_W) begin : g_uid_hi
        logic unused_uid_hi;
        assign unused_uid_hi = ^bus.rsp_uid[ID_WIDTH-1:SLOT_W];
    end

    // A response is accepted only into an empty slot; a busy slot stalls.
    assign bus.rsp_ready = ~slot_valid[wr_row][wr_col];
    assign wr_en         = bus.rsp_valid & bus.rsp_ready;

    // A row is eligible when the slot at its head column holds a response.
    always_comb begin
        eligible = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            eligible[ROW_W'(r)] = slot_valid[ROW_W'(r)][head[ROW_W'(r)]];
        end
    end

    // Round-robin pick of the first eligible row at or after rr_ptr.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        any_elig  = 1'b0;
        grant_row = '0;
        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_ROWS;
            if (!any_elig && eligible[ROW_W'(idx)]) begin
                any_elig  = 1'b1;
                grant_row = ROW_W'(idx);
            end
        end
        grant_col = head[grant_row];
    end

    // Release when something is eligible and the output register can take it.
    assign load = any_elig & (~bus.out_valid | bus.out_ready) & ~rst;

    // Free pulse is coincident with the load so the allocator answers in-cycle.
    assign bus.free_req          = load;
    assign bus.unique_id_to_free = load ? ID_WIDTH'({grant_row, grant_col}) : '0;

    // Slot occupancy, per-row head column and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                slot_valid[r] <= '0;
                head[r]       <= '0;
            end
            rr_ptr <= '0;
        end else begin
            if (wr_en) begin
                slot_valid[wr_row][wr_col] <= 1'b1;
            end
            if (load) begin
                slot_valid[grant_row][grant_col] <= 1'b0;
                head[grant_row] <= COL_W'(grant_col + 1'b1);
                rr_ptr <= (grant_row == ROW_W'(NUM_ROWS - 1)) ? '0
                                                              : ROW_W'(grant_row + 1'b1);
            end
        end
    end

    // Payload storage; contents are qualified by slot_valid so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pay_mem[{wr_row, wr_col}] <= {bus.rsp_data, bus.rsp_resp};
        end
    end

    // Single output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_id    <= '0;
            bus.out_data  <= '0;
            bus.out_resp  <= '0;
        end else if (load) begin
            bus.out_valid                <= 1'b1;
            bus.out_id                   <= bus.restored_id;
            {bus.out_data, bus.out_resp} <= pay_mem[{grant_row, grant_col}];
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

`ifdef ROB_STATS_EN
    // Valid-slot count and sticky duplicate-slot flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
            dup_err   <= 1'b0;
        end else begin
            if (wr_en && !load) begin
                occupancy <= occupancy + 1'b1;
            end else if (load && !wr_en) begin
                occupancy <= occupancy - 1'b1;
            end
            if (bus.rsp_valid && !bus.rsp_ready) begin
                dup_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/response_reorder_buffer.md
Name: response_reorder_buffer

Overview:
- Response-side counterpart of the unique-ID allocator.
- Accepts single-beat responses tagged with a unique ID {row, col} that return out of order, and buffers them in a NUM_ROWS x NUM_COLS slot matrix.
- Releases responses per row strictly in column (issue) order.
- On each release, drives the allocator free interface and forwards the restored original ID with the response.

Parameters:
- ID_WIDTH, 16, width of unique and original IDs.
- MAX_OUTSTANDING, 16, sizing basis.
- NUM_ROWS, MAX_OUTSTANDING, rows (one per bound original ID).
- NUM_COLS, MAX_OUTSTANDING, slots per row.
- DATA_WIDTH, 32, response payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rsp_valid  in  1  incoming response valid.
- rsp_ready  out  1  incoming response accepted.
- rsp_uid  in  ID_WIDTH  unique ID; row = bits [ROW_W+COL_W-1:COL_W], col = bits [COL_W-1:0].
- rsp_data  in  DATA_WIDTH  payload.
- rsp_resp  in  2  response code.
- out_valid  out  1  ordered response valid.
- out_ready  in  1  downstream accept.
- out_id  out  ID_WIDTH  restored original ID.
- out_data  out  DATA_WIDTH  payload.
- out_resp  out  2  response code.
- free_req  out  1  one-cycle free pulse to the allocator.
- unique_id_to_free  out  ID_WIDTH  {zero pad, row, head col} being freed.
- restored_id  in  ID_WIDTH  combinational original ID returned by the allocator for unique_id_to_free.

Behaviour:
- Reset (synchronous, active-high):
  - All slot valid bits = 0; head[r] = 0 for every row; round-robin pointer = 0.
  - out_valid = 0; out_id, out_data, out_resp = 0.
  - free_req = 0; unique_id_to_free = 0; rsp_ready = 1 (asserted once no slot is valid).
  - Reset mid-operation discards all buffered and held responses; no free is issued for them.
- Write side:
  - rsp_ready = ~slot_valid[row][col] of the slot addressed by rsp_uid.
  - On rsp_valid & rsp_ready, store {data, resp} and set slot_valid at the next edge.
  - A response to an already-valid slot stalls (rsp_ready = 0) until that slot drains.
- Eligibility: row r is eligible iff slot_valid[r][head[r]] = 1.
- Arbitration:
  - Round-robin over eligible rows, starting at rr_ptr.
  - After each grant, rr_ptr = granted row + 1 (wraps modulo NUM_ROWS).
- Output stage: a single register.
  - load = any row eligible & (~out_valid | out_ready).
  - On load, in the same cycle: free_req = 1; unique_id_to_free = {0, granted row, head[row]}; restored_id is sampled into out_id; data and resp are copied into the out registers.
  - At the following edge: out_valid = 1, slot_valid cleared, head[row] incremented modulo NUM_COLS (natural wrap of COL_W bits).
  - free_req fires exactly once per released response, coincident with the load.
- Hold rule: while out_valid & ~out_ready, the output registers stay stable and no load occurs.
- Throughput: back-to-back release is 1 per cycle when out_ready is held high.
- Latency: a response accepted at edge N (head slot, no contention) gives out_valid high after edge N+1.
- Simultaneous events:
  - A write and a drain in the same cycle never target the same slot, because a drain requires valid = 1 and a write requires valid = 0.
  - A write to row r's head slot in the cycle row r is not yet eligible becomes eligible the next cycle.
  - Simultaneous writes to the other slots are unaffected by a drain.
- Wrap-around: after head = NUM_COLS-1, head returns to 0, matching the allocator's column pointer wrap.
- Full: when all slots are valid, rsp_ready is 0 for every uid until one slot drains.
- Empty: out_valid falls after the last accepted output if no row is eligible.

Optional Feature:
- Macro: ROB_STATS_EN.
- With the macro defined, two extra outputs are present:
  - occupancy (width $clog2(NUM_ROWS*NUM_COLS+1)): count of valid slots; +1 on write, -1 on drain, unchanged when both happen in the same cycle; reset 0.
  - dup_err (1): sticky flag set when rsp_valid targets an already-valid slot; cleared only by rst.
- Without the macro, neither port exists and no counting logic is generated.

Test Plan:
- In-order release: with NUM_COLS = 16, write uid 0x0002, then 0x0001, then 0x0000 (row 0) -> out sequence col 0, 1, 2. out_valid is first high 2 edges after the uid 0x0000 write; free_req pulses with unique_id_to_free 0x0000, 0x0001, 0x0002.
- Restored ID passthrough: allocator model returns 0x00AB for uid 0x0010 -> out_id = 0x00AB, out_data equals the written data.
- Backpressure: out_ready = 0 for 5 cycles with rows 0 and 1 eligible -> out registers stable, no free_req. Release out_ready -> two consecutive outputs alternating row 0 then row 1 via round-robin.
- Wrap: send 17 responses on row 3 in order with draining -> the 17th has unique_id_to_free 0x0030 (col wrapped to 0).
- Duplicate slot: write uid 0x0005 twice without draining -> rsp_ready = 0 on the second attempt; dup_err = 1 when ROB_STATS_EN is defined.
- Reset mid-flight: 4 slots valid, out_valid = 1, assert rst -> out_valid = 0, no free_req, and all rsp_ready = 1 the next cycle.
